// File: rtl/vga_raster_gen_if.sv
// Bus between the raster generator and its consumers (draw_sprite and the VGA pins).
// The generator takes the master side; draw_sprite / the bench take the slave side.
interface vga_raster_gen_if;
    logic [9:0] spr_y;
    logic       spr_draw;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       spr_start;
    logic       frame_end;
    logic       hsync;
    logic       vsync;
    logic [7:0] rgb;

    modport master (
        input  spr_y, spr_draw,
        output pixel_x, pixel_y, video_on, spr_start, frame_end, hsync, vsync, rgb
    );

    modport slave (
        output spr_y, spr_draw,
        input  pixel_x, pixel_y, video_on, spr_start, frame_end, hsync, vsync, rgb
    );
endinterface

// File: rtl/vga_raster_gen.sv
// VGA raster timing generator and pixel mux.
// Free-running h/v counters on the pixel clock, a per-frame sprite-start pulse
// in the horizontal blanking before the sprite's first line, and registered
// hsync/vsync/rgb outputs that trail pixel_x/pixel_y by one clock.
module vga_raster_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic [7:0]  SPR_COLOR = 8'b000_111_00,
    parameter logic [7:0]  BG_COLOR  = 8'b000_000_00
) (
    input  logic              clk,
    input  logic              rst,
    vga_raster_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_PRE  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] spr_y_q;
    logic [9:0] tgt;
    logic       h_last;
    logic       v_last;
    logic       active;
    logic       spr_start_q;
    logic       hsync_q;
    logic       vsync_q;
    logic [7:0] rgb_q;

    // Position decodes and the line on which the sprite start pulse is issued.
    always_comb begin
        h_last = (h == H_LAST);
        v_last = (v == V_LAST);
        active = (h < H_ACT) && (v < V_ACT);
        // Sprite on line 0 is armed from the last line of the previous frame.
        tgt    = (spr_y_q != '0) ? (spr_y_q - 10'd1) : V_LAST;
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : (v + 10'd1);
        end else begin
            h <= h + 10'd1;
        end
    end

    // Capture the sprite line once per frame, on entry to the frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spr_y_q <= V_ACT;
        end else if (h_last && v_last) begin
            spr_y_q <= bus.spr_y;
        end
    end

    // One-cycle sprite arm pulse, high during h==H_ACTIVE of the target line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spr_start_q <= 1'b0;
        end else begin
            spr_start_q <= (h == H_PRE) && (v == tgt) && (spr_y_q < V_ACT);
        end
    end

    // Registered sync and colour outputs, one clock behind pixel_x/pixel_y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= !((h >= HS_BEG) && (h < HS_END));
            vsync_q <= !((v >= VS_BEG) && (v < VS_END));
            rgb_q   <= active ? (bus.spr_draw ? SPR_COLOR : BG_COLOR) : '0;
        end
    end

    assign bus.pixel_x   = h;
    assign bus.pixel_y   = v;
    assign bus.video_on  = active;
    assign bus.frame_end = h_last && v_last;
    assign bus.spr_start = spr_start_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.rgb       = rgb_q;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Self-checking bench for vga_raster_gen, run with a scaled-down raster so that
// several whole frames fit in a short simulation.
module tb_vga_raster_gen;

    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 4;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VA  = 30;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;
    localparam logic [7:0] SPR = 8'b000_111_00;
    localparam logic [7:0] BG  = 8'b000_000_00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #20 clk = ~clk;

    vga_raster_gen_if vif ();

    vga_raster_gen #(
        .H_ACTIVE (HA),  .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA),  .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SPR_COLOR(SPR), .BG_COLOR(BG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: t = clock edges since reset release; raster position is
    // plain division/modulo of t.
    function automatic int mh(input int tt);
        return tt % HT;
    endfunction

    function automatic int mv(input int tt);
        return (tt / HT) % VT;
    endfunction

    function automatic logic start_exp(input int tt, input int s);
        int tg;
        tg = (s == 0) ? VT - 1 : s - 1;
        return (s < VA) && (mh(tt) == HA) && (mv(tt) == tg);
    endfunction

    int         t;
    int         sy;
    logic [7:0] e_rgb;
    logic       e_hs;
    logic       e_vs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t     <= 0;
            sy    <= VA;
            e_rgb <= 8'h00;
            e_hs  <= 1'b1;
            e_vs  <= 1'b1;
        end else begin
            e_rgb <= (mh(t) < HA && mv(t) < VA) ? (vif.spr_draw ? SPR : BG) : 8'h00;
            e_hs  <= !(mh(t) >= HA + HFP && mh(t) < HA + HFP + HS);
            e_vs  <= !(mv(t) >= VA + VFP && mv(t) < VA + VFP + VS);
            if (mh(t) == HT - 1 && mv(t) == VT - 1) sy <= int'(vif.spr_y);
            t <= t + 1;
        end
    end

    // Advance negedge by negedge until the model sits at (x, y).
    task automatic wait_pos(input int x, input int y);
        int n;
        n = 0;
        while (!(mh(t) == x && mv(t) == y) && n < FT + 2) begin
            @(negedge clk);
            n++;
        end
        if (!(mh(t) == x && mv(t) == y)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pos timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", mh(t), mv(t), x, y);
        end
    endtask

    task automatic test_reset();
        logic [30:0] got;
        vif.spr_y    = 10'd0;
        vif.spr_draw = 1'b0;
        rst          = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        got = {vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.rgb, vif.spr_start};
        if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold: got x/y/hs/vs/rgb/start=%h want %h", got,
                     {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0});
        end
        rst = 1'b1;
        repeat (37 + $urandom_range(0, 20)) @(negedge clk);
        // Assert mid-cycle: outputs must clear without waiting for a clock edge.
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        vectors++;
        got = {vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.rgb, vif.spr_start};
        if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: got x/y/hs/vs/rgb/start=%h want %h", got,
                     {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        logic [32:0] got;
        logic [32:0] exp;
        int          fe_cnt;
        fe_cnt = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            exp = {10'(mh(t)), 10'(mv(t)), (mh(t) < HA && mv(t) < VA), start_exp(t, sy),
                   (mh(t) == HT - 1 && mv(t) == VT - 1), e_hs, e_vs, e_rgb};
            got = {vif.pixel_x, vif.pixel_y, vif.video_on, vif.spr_start,
                   vif.frame_end, vif.hsync, vif.vsync, vif.rgb};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL free_run t=%0d: got %h want %h", t, got, exp);
            end
            if (vif.frame_end === 1'b1) fe_cnt++;
            vif.spr_draw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) vif.spr_y = 10'($urandom_range(0, VA + 5));
            @(negedge clk);
        end
        vectors++;
        if (fe_cnt != 2) begin
            miscompares++;
            $display("FAIL frame_end_count: got %0d want 2", fe_cnt);
        end
        vif.spr_draw = 1'b0;
    endtask

    task automatic test_sync();
        int   hs_low;
        int   vs_low;
        logic hs_prev;
        hs_low  = 0;
        vs_low  = 0;
        hs_prev = vif.hsync;
        for (int i = 0; i < FT; i++) begin
            if (vif.hsync === 1'b0) hs_low++;
            if (vif.vsync === 1'b0) vs_low++;
            if (hs_prev === 1'b1 && vif.hsync === 1'b0) begin
                vectors++;
                if (mh(t - 1) != HA + HFP) begin
                    miscompares++;
                    $display("FAIL hsync_fall: fell with prior h=%0d want %0d", mh(t - 1), HA + HFP);
                end
            end
            hs_prev = vif.hsync;
            @(negedge clk);
        end
        vectors += 2;
        if (hs_low != VT * HS) begin
            miscompares++;
            $display("FAIL hsync_low_cycles: got %0d want %0d", hs_low, VT * HS);
        end
        if (vs_low != VS * HT) begin
            miscompares++;
            $display("FAIL vsync_low_cycles: got %0d want %0d", vs_low, VS * HT);
        end
    endtask

    task automatic test_spr_pos();
        int vals[5];
        int cnt;
        int px;
        int py;
        vals = '{20, 0, VA - 1, VA, 1023};
        foreach (vals[k]) begin
            vif.spr_y = 10'(vals[k]);
            @(negedge clk);
            wait_pos(0, 0);
            cnt = 0;
            px  = -1;
            py  = -1;
            for (int i = 0; i < FT; i++) begin
                if (vif.spr_start === 1'b1) begin
                    cnt++;
                    px = int'(vif.pixel_x);
                    py = int'(vif.pixel_y);
                end
                @(negedge clk);
            end
            vectors++;
            if (cnt != ((vals[k] < VA) ? 1 : 0)) begin
                miscompares++;
                $display("FAIL spr_start_count spr_y=%0d: got %0d want %0d", vals[k], cnt,
                         (vals[k] < VA) ? 1 : 0);
            end
            if (vals[k] < VA) begin
                vectors++;
                if (px != HA || py != ((vals[k] == 0) ? VT - 1 : vals[k] - 1)) begin
                    miscompares++;
                    $display("FAIL spr_start_pos spr_y=%0d: got x=%0d y=%0d want x=%0d y=%0d",
                             vals[k], px, py, HA, (vals[k] == 0) ? VT - 1 : vals[k] - 1);
                end
            end
        end
    endtask

    task automatic test_rgb();
        wait_pos(10, 5);
        vif.spr_draw = 1'b1;
        @(negedge clk);
        vectors++;
        if (vif.rgb !== SPR) begin
            miscompares++;
            $display("FAIL rgb_sprite: got %h want %h", vif.rgb, SPR);
        end
        vif.spr_draw = 1'b0;
        @(negedge clk);
        vectors++;
        if (vif.rgb !== BG) begin
            miscompares++;
            $display("FAIL rgb_background: got %h want %h", vif.rgb, BG);
        end
        wait_pos(HA + 6, 5);
        vif.spr_draw = 1'b1;
        @(negedge clk);
        vectors++;
        if (vif.rgb !== 8'h00) begin
            miscompares++;
            $display("FAIL rgb_hblank: got %h want 00", vif.rgb);
        end
        vif.spr_draw = 1'b0;
        wait_pos(10, VA + 2);
        vif.spr_draw = 1'b1;
        @(negedge clk);
        vectors++;
        if (vif.rgb !== 8'h00) begin
            miscompares++;
            $display("FAIL rgb_vblank: got %h want 00", vif.rgb);
        end
        vif.spr_draw = 1'b0;
    endtask

    task automatic test_midframe();
        int          cnt;
        int          py;
        int          n;
        logic [30:0] got;
        vif.spr_y = 10'd15;
        @(negedge clk);
        wait_pos(0, 0);
        wait_pos(0, 5);
        vif.spr_y = 10'd25;
        cnt = 0;
        py  = -1;
        n   = 0;
        while (!(mh(t) == 0 && mv(t) == 20) && n < FT) begin
            if (vif.spr_start === 1'b1) begin
                cnt++;
                py = int'(vif.pixel_y);
            end
            @(negedge clk);
            n++;
        end
        vectors++;
        if (cnt != 1 || py != 14) begin
            miscompares++;
            $display("FAIL midframe_change: got %0d pulses at y=%0d want 1 at y=14", cnt, py);
        end
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        vectors++;
        got = {vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.rgb, vif.spr_start};
        if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midframe_reset: got x/y/hs/vs/rgb/start=%h want %h", got,
                     {10'd0, 10'd0, 1'b1, 1'b1, 8'd0, 1'b0});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < FT; i++) begin
            if (vif.spr_start === 1'b1) cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt != 0) begin
            miscompares++;
            $display("FAIL first_frame_after_reset: got %0d pulses want 0", cnt);
        end
        cnt = 0;
        py  = -1;
        for (int i = 0; i < FT; i++) begin
            if (vif.spr_start === 1'b1) begin
                cnt++;
                py = int'(vif.pixel_y);
            end
            @(negedge clk);
        end
        vectors++;
        if (cnt != 1 || py != 24) begin
            miscompares++;
            $display("FAIL second_frame_after_reset: got %0d pulses at y=%0d want 1 at y=24", cnt, py);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sync();
        test_spr_pos();
        test_rgb();
        test_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
